// File: rtl/exe_pkg.sv
// exe_pkg: shared types and decode helpers for the execute stage.
//   op_e    - 5-bit operation code. Codes 0x00-0x09 are register-register
//             ALU ops; the same ALU function with bit 4 set (0x10-0x19)
//             takes the immediate as its second operand.
//   state_e - execute FSM state.
//   is_alu / uses_imm / is_branch / is_mem / writes_rd - decode helpers.
package exe_pkg;

    typedef enum logic [4:0] {
        OP_ADD   = 5'h00,
        OP_SUB   = 5'h01,
        OP_AND   = 5'h02,
        OP_OR    = 5'h03,
        OP_XOR   = 5'h04,
        OP_SLL   = 5'h05,
        OP_SRL   = 5'h06,
        OP_SRA   = 5'h07,
        OP_SLT   = 5'h08,
        OP_SLTU  = 5'h09,
        OP_LUI   = 5'h0A,
        OP_BEQ   = 5'h0B,
        OP_BNE   = 5'h0C,
        OP_BLT   = 5'h0D,
        OP_BGE   = 5'h0E,
        OP_BLTU  = 5'h0F,
        OP_ADDI  = 5'h10,
        OP_SUBI  = 5'h11,
        OP_ANDI  = 5'h12,
        OP_ORI   = 5'h13,
        OP_XORI  = 5'h14,
        OP_SLLI  = 5'h15,
        OP_SRLI  = 5'h16,
        OP_SRAI  = 5'h17,
        OP_SLTI  = 5'h18,
        OP_SLTIU = 5'h19,
        OP_BGEU  = 5'h1A,
        OP_JAL   = 5'h1B,
        OP_JALR  = 5'h1C,
        OP_LW    = 5'h1D,
        OP_SW    = 5'h1E,
        OP_NOP   = 5'h1F
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    // ALU function codes live in the low nibble of the op.
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    function automatic logic is_alu(op_e op);
        return (op[3:0] <= ALU_SLTU);
    endfunction

    function automatic logic uses_imm(op_e op);
        return is_alu(op) && op[4];
    endfunction

    function automatic logic is_branch(op_e op);
        return (op == OP_BEQ)  || (op == OP_BNE)  || (op == OP_BLT) ||
               (op == OP_BGE)  || (op == OP_BLTU) || (op == OP_BGEU);
    endfunction

    function automatic logic is_mem(op_e op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic writes_rd(op_e op);
        return is_alu(op) || (op == OP_LUI) || (op == OP_JAL) ||
               (op == OP_JALR) || (op == OP_LW);
    endfunction

endpackage

// File: rtl/exe_alu.sv
// exe_alu: combinational ALU and branch comparator.
//   op_i      - operation code
//   a_i, b_i  - operands (b_i is already rs2 or imm as the op requires)
//   result_o  - ALU result (b_i for LUI, 0 for non-ALU ops)
//   taken_o   - branch condition true (branch ops only)
module exe_alu
    import exe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  op_e             op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] result_o,
    output logic            taken_o
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt;
    logic           lt_s;
    logic           lt_u;

    assign shamt = b_i[SHW-1:0];
    assign lt_s  = $signed(a_i) < $signed(b_i);
    assign lt_u  = a_i < b_i;

    always_comb begin
        result_o = '0;
        taken_o  = 1'b0;
        if (is_alu(op_i)) begin
            case (op_i[3:0])
                ALU_ADD:  result_o = a_i + b_i;
                ALU_SUB:  result_o = a_i - b_i;
                ALU_AND:  result_o = a_i & b_i;
                ALU_OR:   result_o = a_i | b_i;
                ALU_XOR:  result_o = a_i ^ b_i;
                ALU_SLL:  result_o = a_i << shamt;
                ALU_SRL:  result_o = a_i >> shamt;
                ALU_SRA:  result_o = $unsigned($signed(a_i) >>> shamt);
                ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, lt_s};
                ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, lt_u};
                default:  result_o = '0;
            endcase
        end else begin
            case (op_i)
                OP_LUI:  result_o = b_i;
                OP_BEQ:  taken_o  = (a_i == b_i);
                OP_BNE:  taken_o  = (a_i != b_i);
                OP_BLT:  taken_o  = lt_s;
                OP_BGE:  taken_o  = !lt_s;
                OP_BLTU: taken_o  = lt_u;
                OP_BGEU: taken_o  = !lt_u;
                default: begin
                    result_o = '0;
                    taken_o  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/exe_stage.sv
// exe_stage: execute stage with a one-entry registered output.
//   clk_i, rst_i                 - clock, async active-high reset
//   in_valid_i / in_ready_o      - upstream handshake
//   in_op_i, in_pc_i, in_rs1_i, in_rs2_i, in_imm_i, in_rd_i - decoded op
//   mem_req_o / mem_ack_i        - memory handshake (req held until ack)
//   mem_we_o, mem_addr_o, mem_wdata_o, mem_rdata_i - memory data path
//   out_valid_o / out_ready_i    - writeback handshake
//   out_we_o, out_rd_o, out_data_o, out_err_o - writeback beat
//   jmp_en_o, jmp_addr_o, clr_o  - fetch redirect / younger-stage flush
//
// state | meaning
// IDLE  | accept ops; ALU/branch/jump/misaligned beats load the output reg
// MEM   | mem_req held with stable addr/data/we until mem_ack
// OUT   | memory beat presented; back to IDLE on out_ready
module exe_stage
    import exe_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int RESET_PC_OFS = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [4:0]      in_op_i,
    input  logic [XLEN-1:0] in_pc_i,
    input  logic [XLEN-1:0] in_rs1_i,
    input  logic [XLEN-1:0] in_rs2_i,
    input  logic [XLEN-1:0] in_imm_i,
    input  logic [4:0]      in_rd_i,
    output logic            mem_req_o,
    input  logic            mem_ack_i,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic            out_we_o,
    output logic [4:0]      out_rd_o,
    output logic [XLEN-1:0] out_data_o,
    output logic            out_err_o,
    output logic            jmp_en_o,
    output logic [XLEN-1:0] jmp_addr_o,
    output logic            clr_o
);

    localparam logic [XLEN-1:0] LINK_OFS  = XLEN'(RESET_PC_OFS);
    localparam logic [XLEN-1:0] JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};

    state_e          state_q;
    logic            out_valid_q, out_we_q, out_err_q;
    logic [4:0]      out_rd_q;
    logic [XLEN-1:0] out_data_q;
    logic            jmp_en_q;
    logic [XLEN-1:0] jmp_addr_q;
    logic            mem_req_q, mem_we_q;
    logic [XLEN-1:0] mem_addr_q, mem_wdata_q;

    op_e             op;
    logic [XLEN-1:0] b_sel, alu_res, agu_sum, jmp_tgt, beat_data;
    logic            br_taken, misalign, jump, beat_we, in_fire;

    assign op = op_e'(in_op_i);

    assign b_sel = (uses_imm(op) || op == OP_LUI) ? in_imm_i : in_rs2_i;

    exe_alu #(.XLEN(XLEN)) u_alu (
        .op_i     (op),
        .a_i      (in_rs1_i),
        .b_i      (b_sel),
        .result_o (alu_res),
        .taken_o  (br_taken)
    );

    assign agu_sum  = in_rs1_i + in_imm_i;
    assign misalign = is_mem(op) && (agu_sum[1:0] != 2'b00);
    assign jump     = (is_branch(op) && br_taken) || op == OP_JAL || op == OP_JALR;
    assign jmp_tgt  = (op == OP_JALR) ? (agu_sum & JALR_MASK) : (in_pc_i + in_imm_i);
    assign beat_we  = writes_rd(op) && (in_rd_i != 5'd0) && !misalign;

    // Misaligned accesses report the faulting address in out_data.
    always_comb begin
        beat_data = alu_res;
        if (op == OP_JAL || op == OP_JALR)
            beat_data = in_pc_i + LINK_OFS;
        else if (is_mem(op))
            beat_data = agu_sum;
    end

    // Reset also holds in_ready low so every output reads 0 while in reset.
    assign in_ready_o = !rst_i && (state_q == ST_IDLE) && (!out_valid_q || out_ready_i);
    assign in_fire    = in_valid_i && in_ready_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_we_q    <= 1'b0;
            out_err_q   <= 1'b0;
            out_rd_q    <= '0;
            out_data_q  <= '0;
            jmp_en_q    <= 1'b0;
            jmp_addr_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            jmp_en_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (out_valid_q && out_ready_i) begin
                        out_valid_q <= 1'b0;
                        out_err_q   <= 1'b0;
                    end
                    if (in_fire) begin
                        if (jump) begin
                            jmp_en_q   <= 1'b1;
                            jmp_addr_q <= jmp_tgt;
                        end
                        out_we_q <= beat_we;
                        out_rd_q <= in_rd_i;
                        if (is_mem(op) && !misalign) begin
                            state_q     <= ST_MEM;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= (op == OP_SW);
                            mem_addr_q  <= agu_sum;
                            mem_wdata_q <= in_rs2_i;
                        end else begin
                            out_valid_q <= 1'b1;
                            out_data_q  <= beat_data;
                            out_err_q   <= misalign;
                        end
                    end
                end
                ST_MEM: begin
                    if (mem_ack_i) begin
                        state_q     <= ST_OUT;
                        mem_req_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        out_err_q   <= 1'b0;
                        out_data_q  <= mem_we_q ? '0 : mem_rdata_i;
                    end
                end
                ST_OUT: begin
                    if (out_ready_i) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_we_o    = out_we_q;
    assign out_rd_o    = out_rd_q;
    assign out_data_o  = out_data_q;
    assign out_err_o   = out_err_q;
    assign jmp_en_o    = jmp_en_q;
    assign clr_o       = jmp_en_q;
    assign jmp_addr_o  = jmp_addr_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule
